autoplay_sequencer: RTL
=======================

// Module: autoplay_sequencer
// PURPOSE
//  Parametrised song sequencer for the piano autoplay path. Walks a song table
//  in external synchronous ROM and drives note/note_on to the buzzer and LED
//  blocks. Supports play, pause/resume, repeat, and a learn mode that waits for
//  the correct key before sounding each note. Sits between the debounced
//  buttons/keyControl and the buzzer, LED and display blocks.
// PARAMETERS
//  CLK_HZ     100_000_000  clk frequency in Hz
//  TICK_HZ    16           duration unit rate; one tick = CLK_HZ/TICK_HZ clocks
//  NUM_SONGS  8            songs in the table
//  SONG_W     3            song index width, equal to clog2(NUM_SONGS)
//  STEP_W     6            step index width; each song has 2**STEP_W entries
//  NOTE_W     4            note code width; code 0 is a rest
//  DUR_W      4            note duration width, in ticks
//  GAP_TICKS  1            silent ticks inserted after every note
// PORTS
//  clk        in   1                 clock
//  rst        in   1                 reset
//  start      in   1                 debounced 1-cycle pulse; begin the selected song
//  back       in   1                 debounced pulse; abort and return to IDLE
//  pause      in   1                 debounced pulse; toggle pause
//  repeat_en  in   1                 1: restart the song at end instead of stopping
//  learn_en   in   1                 1: learn mode; sampled on start only
//  song_sel   in   SONG_W            song index; sampled on start only
//  key_on     in   1                 user key pressed (level)
//  key        in   NOTE_W            user key code
//  rom_addr   out  SONG_W+STEP_W     {song, step}
//  rom_data   in   NOTE_W+DUR_W      {note, dur}; valid one cycle after rom_addr
//  note       out  NOTE_W            current or expected note
//  note_on    out  1                 sound enable
//  state_o    out  3                 FSM state code, for the display
//  step_o     out  STEP_W            current step
//  err_cnt    out  8                 wrong keys in learn mode; saturates at 255
//  song_done  out  1                 1-cycle pulse at end of song
// BEHAVIOUR
//  - Reset is asynchronous and active-high. It clears every output, step,
//    counters and the latched song/mode, and puts the FSM in IDLE.
//  - Event priority: back > pause > start. back in any state gives IDLE on the
//    next cycle, with note_on=0. err_cnt is held.
//  - Tick generator: its prescaler is cleared on every FETCH. It counts only
//    in PLAY and GAP and freezes in PAUSE.
//  - IDLE: note_on=0. On start, latch song_sel and learn_en, set step=0,
//    clear err_cnt, go to FETCH. start in any other state is ignored.
//  - FETCH: drive rom_addr for 1 cycle. DECODE uses rom_data in the next
//    cycle (2 cycles per fetch):
//      - dur==0 -> DONE (end marker, whatever the note value).
//      - learn and note!=0 -> LEARN_WAIT.
//      - otherwise -> PLAY, with dcnt=dur.
//  - PLAY: note_on = (note!=0), so a rest is silent. On a tick with dcnt==1,
//    go to GAP; otherwise dcnt decrements on each tick.
//  - GAP: note_on=0 for GAP_TICKS ticks, then step+1 and FETCH.
//    GAP_TICKS=0 skips GAP.
//  - Step wrap: step at all-ones with no end marker -> DONE after its GAP.
//  - LEARN_WAIT: note shows the expected code, note_on=0. Only a rising edge of
//    key_on is evaluated:
//      - key==note -> PLAY with dcnt=dur.
//      - key!=note -> err_cnt+1, stay in LEARN_WAIT.
//  - PAUSE: entered from PLAY, GAP or LEARN_WAIT. Saves the return state.
//    note_on=0; dcnt, prescaler and step are held. A second pause returns to
//    the saved state and resumes mid-note. pause in other states is ignored.
//  - DONE: song_done=1 for exactly one cycle. Then, if repeat_en, step=0 and
//    FETCH; otherwise IDLE. err_cnt is held until the next start.
//  - song_sel/learn_en changes during a song have no effect.
//  - State codes: IDLE=0 FETCH=1 DECODE=2 PLAY=3 GAP=4 LEARN_WAIT=5 PAUSE=6
//    DONE=7.
// STRUCTURE
//  - piano_pkg: state encoding, NOTE_REST=0, END marker rule (dur==0), and
//    the rom_data field slices.
//  - Sub-module piano_tick_gen: parametrised prescaler with clear and enable
//    inputs and a tick pulse output.
//  - Sequencer FSM, dcnt, step and err_cnt stay in this module.
// TESTING
//  All scenarios use CLK_HZ=100, TICK_HZ=10 (10 clocks/tick), GAP_TICKS=1 and a
//  behavioural ROM.
//  1. Song 2 = {(5,3),(0,2),(7,1),(x,0)}, start -> note 5 on for 30 clks, gap
//     10, silence 20, gap 10, note 7 for 10, gap 10, song_done pulse, IDLE.
//  2. Same song, pause 12 clks into note 5 -> note_on=0 and dcnt frozen for
//     100 clks. Second pause -> 18 clks of note 5 remain.
//  3. learn_en=1 on song 2: keys 3,4 pressed -> err_cnt=2, no sound. Key 5
//     pressed -> note 5 sounds for 30 clks. The rest plays without a key.
//  4. repeat_en=1 -> song_done pulses, step_o returns to 0, playback restarts.
//     back mid-note -> IDLE next cycle, note_on=0.
//  5. Same-cycle events: back+pause -> IDLE. start during PLAY -> ignored.
//     rst asserted mid-note -> all outputs 0 asynchronously.
//  6. Song with no end marker -> 64 steps play, then DONE via step wrap.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared encodings for the piano autoplay sequencer: FSM state codes,
// the rest note and the {note, dur} song-table word layout.
package piano_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FETCH      = 3'd1,
        S_DECODE     = 3'd2,
        S_PLAY       = 3'd3,
        S_GAP        = 3'd4,
        S_LEARN_WAIT = 3'd5,
        S_PAUSE      = 3'd6,
        S_DONE       = 3'd7
    } seq_state_t;

    localparam int NOTE_REST = 0;

    // A table word is {note, dur} with dur in the low dur_w bits.
    function automatic int rom_dur(input int data, input int dur_w);
        return data & ((1 << dur_w) - 1);
    endfunction

    function automatic int rom_note(input int data, input int dur_w);
        return data >> dur_w;
    endfunction

    // A zero duration ends the song regardless of the note field.
    function automatic logic is_end_marker(input int dur);
        return dur == 0;
    endfunction

endpackage

// File: rtl/piano_tick_gen.sv
// Duration-unit prescaler: one tick every DIV enabled clocks; holds its
// count while disabled so a paused note resumes mid-tick.
module piano_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/autoplay_sequencer.sv
// Song sequencer for the piano autoplay path: walks the song table in ROM and
// drives note/note_on, with pause/resume, repeat and a key-gated learn mode.
module autoplay_sequencer
    import piano_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 16,
    parameter int NUM_SONGS = 8,
    parameter int SONG_W    = 3,
    parameter int STEP_W    = 6,
    parameter int NOTE_W    = 4,
    parameter int DUR_W     = 4,
    parameter int GAP_TICKS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     back,
    input  logic                     pause,
    input  logic                     repeat_en,
    input  logic                     learn_en,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic                     key_on,
    input  logic [NOTE_W-1:0]        key,
    output logic [SONG_W+STEP_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]  rom_data,
    output logic [NOTE_W-1:0]        note,
    output logic                     note_on,
    output logic [2:0]               state_o,
    output logic [STEP_W-1:0]        step_o,
    output logic [7:0]               err_cnt,
    output logic                     song_done
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [NOTE_W-1:0] REST     = NOTE_W'(NOTE_REST);

    seq_state_t        state, ret, run_nxt, step_end;
    logic [SONG_W-1:0] song;
    logic              learn;
    logic [STEP_W-1:0] step;
    logic [DUR_W-1:0]  dcnt, dur_r;
    logic [GAP_W-1:0]  gcnt;
    logic              key_prev;
    logic              tick, tick_clr, tick_en;
    logic [NOTE_W-1:0] rom_note_f;
    logic [DUR_W-1:0]  rom_dur_f;

    assign rom_dur_f  = DUR_W'(rom_dur(int'(rom_data), DUR_W));
    assign rom_note_f = NOTE_W'(rom_note(int'(rom_data), DUR_W));

    assign tick_clr = (state == S_FETCH);
    assign tick_en  = (state == S_PLAY) || (state == S_GAP);

    piano_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    assign rom_addr = {song, step};
    assign state_o  = state;
    assign step_o   = step;

    // Where PLAY/GAP go on this clock; a coincident pause saves this as the
    // return state so no tick is lost when pause lands on a tick edge.
    assign step_end = (&step) ? S_DONE : S_FETCH;

    always_comb begin
        run_nxt = state;
        if (state == S_PLAY && tick && dcnt == DUR_W'(1))
            run_nxt = (GAP_TICKS == 0) ? step_end : S_GAP;
        else if (state == S_GAP && tick && gcnt == GAP_LAST)
            run_nxt = step_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            ret       <= S_IDLE;
            song      <= '0;
            learn     <= 1'b0;
            step      <= '0;
            dcnt      <= '0;
            dur_r     <= '0;
            gcnt      <= '0;
            note      <= '0;
            note_on   <= 1'b0;
            song_done <= 1'b0;
            err_cnt   <= '0;
            key_prev  <= 1'b0;
        end else begin
            note_on   <= 1'b0;
            song_done <= 1'b0;
            key_prev  <= key_on;
            if (back) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        // Out-of-range selections fall back to song 0.
                        song    <= (int'(song_sel) < NUM_SONGS) ? song_sel : '0;
                        learn   <= learn_en;
                        step    <= '0;
                        err_cnt <= '0;
                        state   <= S_FETCH;
                    end
                    S_FETCH: state <= S_DECODE;
                    S_DECODE: begin
                        note  <= rom_note_f;
                        dur_r <= rom_dur_f;
                        if (is_end_marker(int'(rom_dur_f))) begin
                            state     <= S_DONE;
                            song_done <= 1'b1;
                        end else if (learn && rom_note_f != REST) begin
                            state <= S_LEARN_WAIT;
                        end else begin
                            state   <= S_PLAY;
                            dcnt    <= rom_dur_f;
                            note_on <= (rom_note_f != REST);
                        end
                    end
                    S_PLAY, S_GAP: begin
                        if (state == S_PLAY && tick) dcnt <= dcnt - 1'b1;
                        if (state == S_GAP && tick)  gcnt <= gcnt + 1'b1;
                        if (state == S_PLAY && run_nxt == S_GAP) gcnt <= '0;
                        if (run_nxt == S_FETCH) step <= step + 1'b1;
                        if (pause) begin
                            state <= S_PAUSE;
                            ret   <= run_nxt;
                        end else begin
                            state     <= run_nxt;
                            note_on   <= (run_nxt == S_PLAY) && (note != REST);
                            song_done <= (run_nxt == S_DONE);
                        end
                    end
                    S_LEARN_WAIT: begin
                        if (pause) begin
                            state <= S_PAUSE;
                            ret   <= S_LEARN_WAIT;
                        end else if (key_on && !key_prev) begin
                            if (key == note) begin
                                state   <= S_PLAY;
                                dcnt    <= dur_r;
                                note_on <= 1'b1;
                            end else if (err_cnt != 8'hFF) begin
                                err_cnt <= err_cnt + 1'b1;
                            end
                        end
                    end
                    S_PAUSE: if (pause) begin
                        state     <= ret;
                        note_on   <= (ret == S_PLAY) && (note != REST);
                        song_done <= (ret == S_DONE);
                    end
                    S_DONE: begin
                        if (repeat_en) begin
                            step  <= '0;
                            state <= S_FETCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
